// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit
//   Initiator side of the data-memory interface. Takes one load/store request
//   at a time from the MEM stage and sequences word-addressed accesses to
//   MIPS_Data_Memory. Byte and halfword stores use read-modify-write.
//   Little-endian lane order: byte k = bits [8k+7:8k].
//
// Ports
//   CLK, RST_N              clock (rising edge), async active-low reset
//   REQ_VALID/REQ_READY     request handshake (READY high only in IDLE)
//   REQ_WE, REQ_SIZE,       store flag, size (00 byte, 01 half, 1x word),
//   REQ_SIGNED              sign-extend sub-word loads
//   REQ_ADDR, REQ_WDATA     byte address, right-aligned store data
//   RSP_VALID, RSP_RDATA,   one-cycle completion pulse, extended load data,
//   RSP_ERR                 misalignment error (qualified by RSP_VALID)
//   MEM_A, MEM_WD, MEM_WE,  word index, write data, write enable to memory
//   MEM_RD                  combinational read data from memory
//
// Configuration
//   LSU_MISALIGN_TRAP_EN    defined: misaligned requests return RSP_ERR=1
//                           without touching memory.
//                           undefined: RSP_ERR tied 0, the address is
//                           force-aligned and the access proceeds.
module mips_load_store_unit #(
  parameter int ADDR_WORD_BITS = 10
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WE,
  input  logic [1:0]  REQ_SIZE,
  input  logic        REQ_SIGNED,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  output logic        MEM_WE,
  input  logic [31:0] MEM_RD
);

  localparam int AB = ADDR_WORD_BITS + 2;  // byte-address bits actually used

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AB-1:0] addr_r, addr_in_s;
  logic [1:0]    size_r;
  logic          we_r, signed_r;
  logic [31:0]   wdata_r;   // latched store data, replaced by merged word in READ
  logic [31:0]   rdata_r;
  logic          accept_s, misalign_s;
  logic          unused_addr_s;

  // Pick the addressed lane out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Overlay the right-aligned store data onto the addressed lane of a word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  // Size 11 is handled as a word, hence the test on size[1].
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == 2'b01) & off[0]) | (size[1] & (off != 2'b00));
  endfunction

  assign misalign_s = is_misaligned(REQ_SIZE, REQ_ADDR[1:0]);
  assign addr_in_s  = REQ_ADDR[AB-1:0];
`else
  // Clear the offset bits that would make the access misaligned.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
    logic [1:0] r;
    case (size)
      2'b00:   r = off;
      2'b01:   r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  assign misalign_s = 1'b0;
  assign addr_in_s  = {REQ_ADDR[AB-1:2], align_off(REQ_SIZE, REQ_ADDR[1:0])};
`endif

  // High address bits alias onto the implemented range and are deliberately dropped.
  assign unused_addr_s = ^REQ_ADDR[31:AB];
  assign accept_s      = REQ_VALID & (state_r == ST_IDLE);

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (misalign_s)       state_s = ST_RESP;
          else if (!REQ_WE)     state_s = ST_READ;
          else if (REQ_SIZE[1]) state_s = ST_WRITE;
          else                  state_s = ST_READ;   // sub-word store: read first
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:  state_s = we_r ? ST_WRITE : ST_RESP;
      ST_WRITE: state_s = ST_RESP;
      ST_RESP:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Request latch, load capture and read-modify-write merge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_r   <= {AB{1'b0}};
      size_r   <= 2'b00;
      we_r     <= 1'b0;
      signed_r <= 1'b0;
      wdata_r  <= 32'h0000_0000;
      rdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r   <= addr_in_s;
            size_r   <= REQ_SIZE;
            we_r     <= REQ_WE;
            signed_r <= REQ_SIGNED;
            wdata_r  <= REQ_WDATA;
            rdata_r  <= 32'h0000_0000;   // stores and errors respond with zero
          end
        end
        ST_READ: begin
          if (we_r) wdata_r <= store_merge(MEM_RD, size_r, addr_r[1:0], wdata_r);
          else      rdata_r <= load_extract(MEM_RD, size_r, addr_r[1:0], signed_r);
        end
        default: ;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_r;

  // Error flag for the request in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        err_r <= 1'b0;
    else if (accept_s) err_r <= misalign_s;
  end

  assign RSP_ERR = err_r & (state_r == ST_RESP);
`else
  assign RSP_ERR = 1'b0;
`endif

  // All outputs decode straight from registers; MEM_WE drops with the async reset.
  assign REQ_READY = (state_r == ST_IDLE);
  assign RSP_VALID = (state_r == ST_RESP);
  assign RSP_RDATA = rdata_r;
  assign MEM_WE    = (state_r == ST_WRITE);
  assign MEM_WD    = (state_r == ST_WRITE) ? wdata_r : 32'h0000_0000;
  assign MEM_A     = (state_r == ST_IDLE) ? 32'h0000_0000
                   : {{(32-ADDR_WORD_BITS){1'b0}}, addr_r[AB-1:2]};

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a small word memory model.
module tb_mips_load_store_unit;

  logic        CLK, RST_N;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_SIGNED;
  logic [1:0]  REQ_SIZE;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic        RSP_VALID, RSP_ERR, MEM_WE;
  logic [31:0] RSP_RDATA, MEM_A, MEM_WD, MEM_RD;

  logic [31:0] mem [0:1023];
  int          wr_count;
  int          checks;
  int          errors;
  int          wr_before;
  logic        unused_tb;

  mips_load_store_unit #(.ADDR_WORD_BITS(10)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
    .REQ_SIZE(REQ_SIZE), .REQ_SIGNED(REQ_SIGNED), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA),
    .RSP_ERR(RSP_ERR), .MEM_A(MEM_A), .MEM_WD(MEM_WD), .MEM_WE(MEM_WE),
    .MEM_RD(MEM_RD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign MEM_RD    = mem[MEM_A[9:0]];
  assign unused_tb = ^MEM_A[31:10];

  always @(posedge CLK) begin
    if (MEM_WE) begin
      mem[MEM_A[9:0]] <= MEM_WD;
      wr_count <= wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Present one request for a single edge; returns 1 time unit into cycle 1.
  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd);
    REQ_WE = we; REQ_SIZE = size; REQ_SIGNED = sgn; REQ_ADDR = addr; REQ_WDATA = wd;
    REQ_VALID = 1'b1;
    step();
    REQ_VALID = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] exp);
    issue(1'b0, size, sgn, addr, 32'h0);
    check({tag, "_valid_c1"}, {31'd0, RSP_VALID}, 32'd0);
    step();
    check({tag, "_valid_c2"}, {31'd0, RSP_VALID}, 32'd1);
    check({tag, "_rdata"}, RSP_RDATA, exp);
    check({tag, "_err"}, {31'd0, RSP_ERR}, 32'd0);
    step();
  endtask

  initial begin
    checks = 0; errors = 0; wr_count = 0;
    for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    RST_N = 1'b0; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_SIZE = 2'b00;
    REQ_SIGNED = 1'b0; REQ_ADDR = 32'h0; REQ_WDATA = 32'h0;

    // Reset state
    #2;
    check("rst_ready", {31'd0, REQ_READY}, 32'd1);
    check("rst_valid", {31'd0, RSP_VALID}, 32'd0);
    check("rst_rdata", RSP_RDATA, 32'd0);
    check("rst_err", {31'd0, RSP_ERR}, 32'd0);
    check("rst_mem_a", MEM_A, 32'd0);
    check("rst_mem_wd", MEM_WD, 32'd0);
    check("rst_mem_we", {31'd0, MEM_WE}, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // 1: sw 0xDEADBEEF @0x10, then lw @0x10
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    check("sw_we_c1", {31'd0, MEM_WE}, 32'd1);
    check("sw_a_c1", MEM_A, 32'd4);
    check("sw_wd_c1", MEM_WD, 32'hDEADBEEF);
    check("sw_ready_c1", {31'd0, REQ_READY}, 32'd0);
    step();
    check("sw_we_c2", {31'd0, MEM_WE}, 32'd0);
    check("sw_valid_c2", {31'd0, RSP_VALID}, 32'd1);
    check("sw_rdata", RSP_RDATA, 32'd0);
    check("sw_err", {31'd0, RSP_ERR}, 32'd0);
    step();
    check("sw_ready_c3", {31'd0, REQ_READY}, 32'd1);
    check("sw_valid_c3", {31'd0, RSP_VALID}, 32'd0);
    check("sw_mem_a_idle", MEM_A, 32'd0);
    check("sw_mem4", mem[4], 32'hDEADBEEF);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    check("lw_a_c1", MEM_A, 32'd4);
    check("lw_we_c1", {31'd0, MEM_WE}, 32'd0);
    check("lw_valid_c1", {31'd0, RSP_VALID}, 32'd0);
    step();
    check("lw_valid_c2", {31'd0, RSP_VALID}, 32'd1);
    check("lw_rdata", RSP_RDATA, 32'hDEADBEEF);
    step();

    // 2: sb 0xAA @0x12 over 0x11223344
    mem[4] <= 32'h11223344;
    wr_before = wr_count;
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA);
    check("sb_we_c1", {31'd0, MEM_WE}, 32'd0);
    check("sb_a_c1", MEM_A, 32'd4);
    step();
    check("sb_we_c2", {31'd0, MEM_WE}, 32'd1);
    check("sb_wd_c2", MEM_WD, 32'h11AA3344);
    check("sb_valid_c2", {31'd0, RSP_VALID}, 32'd0);
    step();
    check("sb_valid_c3", {31'd0, RSP_VALID}, 32'd1);
    check("sb_rdata", RSP_RDATA, 32'd0);
    step();
    check("sb_mem4", mem[4], 32'h11AA3344);
    check("sb_writes", wr_count - wr_before, 32'd1);

    // 3: sub-word loads from 0x80FF7F01
    mem[4] <= 32'h80FF7F01;
    load_check("lb_11s", 2'b00, 1'b1, 32'h11, 32'h0000007F);
    load_check("lh_12s", 2'b01, 1'b1, 32'h12, 32'hFFFF80FF);
    load_check("lhu_12", 2'b01, 1'b0, 32'h12, 32'h000080FF);
    load_check("lb_12s", 2'b00, 1'b1, 32'h12, 32'hFFFFFFFF);
    load_check("lbu_13", 2'b00, 1'b0, 32'h13, 32'h00000080);
    load_check("lb_10s", 2'b00, 1'b1, 32'h10, 32'h00000001);
    load_check("lw_alias", 2'b10, 1'b0, 32'h1010, 32'h80FF7F01);

    // 4: misaligned word load @0x13
`ifdef LSU_MISALIGN_TRAP_EN
    wr_before = wr_count;
    issue(1'b0, 2'b10, 1'b0, 32'h13, 32'h0);
    check("mis_valid_c1", {31'd0, RSP_VALID}, 32'd1);
    check("mis_err_c1", {31'd0, RSP_ERR}, 32'd1);
    check("mis_rdata_c1", RSP_RDATA, 32'd0);
    check("mis_we_c1", {31'd0, MEM_WE}, 32'd0);
    step();
    check("mis_ready_c2", {31'd0, REQ_READY}, 32'd1);
    check("mis_err_c2", {31'd0, RSP_ERR}, 32'd0);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000BEEF);
    check("mis_sh_err", {31'd0, RSP_ERR}, 32'd1);
    step();
    check("mis_writes", wr_count - wr_before, 32'd0);
    check("mis_mem4", mem[4], 32'h80FF7F01);
`else
    load_check("mis_lw_13", 2'b10, 1'b0, 32'h13, 32'h80FF7F01);
    load_check("mis_lh_13", 2'b01, 1'b0, 32'h13, 32'h000080FF);
`endif

    // 5: reset asserted while a sh is in WRITE
    mem[4] <= 32'h11223344;
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
    check("rstw_we_c1", {31'd0, MEM_WE}, 32'd0);
    step();
    check("rstw_we_c2", {31'd0, MEM_WE}, 32'd1);
    check("rstw_wd_c2", MEM_WD, 32'h1122BEEF);
    #2;
    RST_N = 1'b0;
    #1;
    check("rstw_we_async", {31'd0, MEM_WE}, 32'd0);
    check("rstw_ready", {31'd0, REQ_READY}, 32'd1);
    check("rstw_valid", {31'd0, RSP_VALID}, 32'd0);
    check("rstw_mem_a", MEM_A, 32'd0);
    step();
    check("rstw_valid_late", {31'd0, RSP_VALID}, 32'd0);
    check("rstw_mem4", mem[4], 32'h11223344);
    RST_N = 1'b1;

    // 6: REQ_VALID held high across three loads
    mem[5] <= 32'hCAFEF00D;
    REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_SIGNED = 1'b0; REQ_ADDR = 32'h14;
    REQ_VALID = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("b2b_ready_c%0d", k), {31'd0, REQ_READY}, (k % 3 == 0) ? 32'd1 : 32'd0);
      check($sformatf("b2b_valid_c%0d", k), {31'd0, RSP_VALID}, (k % 3 == 2) ? 32'd1 : 32'd0);
      if (k % 3 == 2) check($sformatf("b2b_rdata_c%0d", k), RSP_RDATA, 32'hCAFEF00D);
    end
    REQ_VALID = 1'b0;
    step();
    check("b2b_ready_end", {31'd0, REQ_READY}, 32'd1);
    check("b2b_valid_end", {31'd0, RSP_VALID}, 32'd0);
    step();
    check("b2b_idle_hold", {31'd0, REQ_READY}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
